mux_arbiter: RTL

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 22 ++
 rtl/mux_arbiter_if.sv | 37 +++
 rtl/mux_arbiter_rr_pick4.sv | 31 +++
 rtl/mux_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the mux_arbiter block.
// Holds the FSM state encoding, the requester count, the select width and
// a one-hot helper used to build the grant vector.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Expand a requester index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] v;
    v    = {N_REQ{1'b0}};
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Bus bundle between the requesters/downstream and mux_arbiter.
//   req         requests, bit i = requester i
//   data_in     packed lanes, lane i at [i*DW +: DW]
//   gnt         one-hot grant pulse
//   sel         index of current winner
//   out_valid   out_data holds a granted word
//   out_data    registered copy of the winner's lane
//   out_ready   downstream accepts the word
//   busy        arbiter is in a transfer
//   timeout_err one-cycle pulse when a transfer is abandoned
// slave = arbiter side, master = requester/downstream side.
interface mux_arbiter_if #(
  parameter int DW = 8
);
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data_in;
  logic [N_REQ-1:0]    gnt;
  logic [SEL_W-1:0]    sel;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_ready;
  logic                busy;
  logic                timeout_err;

  modport slave (
    input  req, data_in, out_ready,
    output gnt, sel, out_valid, out_data, busy, timeout_err
  );

  modport master (
    output req, data_in, out_ready,
    input  gnt, sel, out_valid, out_data, busy, timeout_err
  );

endinterface

// File: rtl/mux_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   req    [3:0] request vector
//   ptr    [1:0] last winner; search starts at ptr+1 (mod 4)
//   winner [1:0] first requesting index found
//   any          at least one request is present
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx_s;

  // Scan from the farthest slot back toward ptr+1 so the closest hit wins last.
  always_comb begin
    winner = 2'd0;
    idx_s  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx_s = ptr + 2'(k);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin 4:1 arbiter with a registered output word.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_arbiter_if.slave (req, data_in, out_ready in;
//          gnt, sel, out_valid, out_data, busy, timeout_err out)
// Optional build macro MUX_ARBITER_TIMEOUT_EN: abandons a word after
// TIMEOUT consecutive stalled cycles and pulses timeout_err; without it the
// word waits indefinitely and timeout_err is tied low.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  mux_arbiter_if.slave bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mux_arbiter: TIMEOUT must be in 1..255");
  end

  state_t           state_r, state_s;
  logic [SEL_W-1:0] ptr_r, ptr_s;
  logic [SEL_W-1:0] winner_s;
  logic             any_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic             valid_r, valid_s;
  logic [DW-1:0]    data_r, data_s;
  logic             busy_r;
  logic             terr_r, terr_s;
`ifdef MUX_ARBITER_TIMEOUT_EN
  logic [7:0]       cnt_r, cnt_s;
`endif

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gnt_s   = {N_REQ{1'b0}};
    sel_s   = sel_r;
    valid_s = valid_r;
    data_s  = data_r;
    terr_s  = 1'b0;
`ifdef MUX_ARBITER_TIMEOUT_EN
    cnt_s   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s = XFER;
          ptr_s   = winner_s;
          gnt_s   = sel_onehot(winner_s);
          sel_s   = winner_s;
          valid_s = 1'b1;
          data_s  = bus.data_in[winner_s*DW +: DW];
`ifdef MUX_ARBITER_TIMEOUT_EN
          cnt_s   = 8'd0;
`endif
        end else begin
          valid_s = 1'b0;
        end
      end
      XFER: begin
        // Requests are not looked at here; the captured word is held as-is.
        if (bus.out_ready) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
`ifdef MUX_ARBITER_TIMEOUT_EN
          // ptr already holds this winner, so abandoning keeps fairness order.
          if (cnt_r == 8'(TIMEOUT - 1)) begin
            state_s = IDLE;
            valid_s = 1'b0;
            terr_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
`else
          valid_s = 1'b1;
`endif
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // Output and pointer registers; reset pointer 3 gives requester 0 first turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r   <= 2'd3;
      gnt_r   <= {N_REQ{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      terr_r  <= 1'b0;
`ifdef MUX_ARBITER_TIMEOUT_EN
      cnt_r   <= 8'd0;
`endif
    end else begin
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      busy_r  <= (state_s == XFER);
      terr_r  <= terr_s;
`ifdef MUX_ARBITER_TIMEOUT_EN
      cnt_r   <= cnt_s;
`endif
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.sel         = sel_r;
  assign bus.out_valid   = valid_r;
  assign bus.out_data    = data_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = terr_r;

endmodule
